// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - requester handshake and register-file write-port bundle
interface regfile_write_arbiter_if #(
   parameter int NUM_REQ   = 3,
   parameter int REG_SIZE  = 32,
   parameter int FILE_SIZE = 32
);
   localparam int RW = $clog2(FILE_SIZE);
   localparam int GW = $clog2(NUM_REQ);

   // Writeback requesters, one slice per source.
   logic [NUM_REQ-1:0]          reqValid;
   logic [NUM_REQ-1:0]          reqReady;
   logic [NUM_REQ*RW-1:0]       reqRegister;
   logic [NUM_REQ*REG_SIZE-1:0] reqData;
   logic                        hold;

   // Register-file write port and monitoring.
   logic [RW-1:0]               writeRegister;
   logic [REG_SIZE-1:0]         writeData;
   logic                        enableWrite;
   logic [GW-1:0]               lastGrant;
   logic [15:0]                 contentionCount;

   modport master (
      output reqValid, reqRegister, reqData, hold,
      input  reqReady, writeRegister, writeData, enableWrite, lastGrant, contentionCount
   );

   modport slave (
      input  reqValid, reqRegister, reqData, hold,
      output reqReady, writeRegister, writeData, enableWrite, lastGrant, contentionCount
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter sharing the register-file write port
module regfile_write_arbiter #(
   parameter int NUM_REQ   = 3,
   parameter int REG_SIZE  = 32,
   parameter int FILE_SIZE = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   regfile_write_arbiter_if.slave  bus
);
   localparam int RW = $clog2(FILE_SIZE);
   localparam int GW = $clog2(NUM_REQ);

   logic [GW-1:0]       ptr;
   logic [GW-1:0]       grantIdx;
   logic                grantFound;
   logic [NUM_REQ-1:0]  readyVec;
   logic                transfer;
   logic [RW-1:0]       selReg;
   logic [REG_SIZE-1:0] selData;
   logic [GW-1:0]       ptrNext;
   logic                contended;
   int                  cand;

   // Search for the first valid requester starting at ptr, wrapping around.
   always_comb begin
      grantFound = 1'b0;
      grantIdx   = '0;
      cand       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = (int'(ptr) + k) % NUM_REQ;
         if (!grantFound && bus.reqValid[cand]) begin
            grantFound = 1'b1;
            grantIdx   = cand[GW-1:0];
         end
      end
   end

   // One-hot ready; suppressed while stalled or in reset so nothing is lost.
   always_comb begin
      readyVec = '0;
      if (grantFound && !bus.hold && reset) begin
         readyVec[grantIdx] = 1'b1;
      end
   end

   // Steer the granted requester's destination and data toward the output stage.
   always_comb begin
      selReg  = '0;
      selData = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (readyVec[i]) begin
            selReg  = bus.reqRegister[i*RW +: RW];
            selData = bus.reqData[i*REG_SIZE +: REG_SIZE];
         end
      end
   end

   assign bus.reqReady = readyVec;
   assign transfer     = |readyVec;
   assign ptrNext      = (int'(grantIdx) == NUM_REQ - 1) ? '0 : grantIdx + 1'b1;
   assign contended    = !bus.hold && ($countones(bus.reqValid) >= 2);

   // Registered write stage, round-robin pointer and saturating contention counter.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ptr                 <= '0;
         bus.lastGrant       <= '0;
         bus.enableWrite     <= 1'b0;
         bus.writeRegister   <= '0;
         bus.writeData       <= '0;
         bus.contentionCount <= '0;
      end else begin
         // Writes to register 0 complete the handshake but never reach the file.
         bus.enableWrite <= transfer && (selReg != '0);
         if (transfer) begin
            bus.writeRegister <= selReg;
            bus.writeData     <= selData;
            bus.lastGrant     <= grantIdx;
            ptr               <= ptrNext;
         end
         if (contended && bus.contentionCount != 16'hFFFF) begin
            bus.contentionCount <= bus.contentionCount + 16'd1;
         end
      end
   end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - scoreboard bench for regfile_write_arbiter
module tb_regfile_write_arbiter;
   localparam int NUM_REQ   = 3;
   localparam int REG_SIZE  = 32;
   localparam int FILE_SIZE = 32;

   typedef struct packed {
      logic [4:0]  wr;
      logic [31:0] wd;
      logic        en;
      logic [1:0]  lg;
      logic [15:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t sbq[$];

   int          mPtr = 0;
   int          mLast = 0;
   int          mCount = 0;
   logic [4:0]  mWr = '0;
   logic [31:0] mWd = '0;
   logic        mEn = 1'b0;

   // Free-running clock.
   always #5 clk = ~clk;

   regfile_write_arbiter_if #(.NUM_REQ(NUM_REQ), .REG_SIZE(REG_SIZE), .FILE_SIZE(FILE_SIZE)) bus ();

   regfile_write_arbiter #(.NUM_REQ(NUM_REQ), .REG_SIZE(REG_SIZE), .FILE_SIZE(FILE_SIZE)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [14:0] regsOf(input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2);
      return {r2, r1, r0};
   endfunction

   function automatic logic [95:0] dataOf(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
      return {d2, d1, d0};
   endfunction

   task automatic drain();
      exp_t e;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk("writeRegister", 32'(bus.writeRegister), 32'(e.wr));
         chk("writeData", bus.writeData, e.wd);
         chk("enableWrite", 32'(bus.enableWrite), 32'(e.en));
         chk("lastGrant", 32'(bus.lastGrant), 32'(e.lg));
         chk("contentionCount", 32'(bus.contentionCount), 32'(e.cnt));
      end
   endtask

   task automatic cycle(input logic [2:0] v, input logic [14:0] regs, input logic [95:0] data,
                        input logic h, input logic r);
      int   g;
      logic [2:0] expReady;
      exp_t e;
      @(negedge clk);
      drain();
      reset           = r;
      bus.hold        = h;
      bus.reqValid    = v;
      bus.reqRegister = regs;
      bus.reqData     = data;
      #1;
      g = -1;
      if (r && !h) begin
         for (int k = 0; k < 3; k++) begin
            if (g < 0 && v[(mPtr + k) % 3]) g = (mPtr + k) % 3;
         end
      end
      expReady = (g >= 0) ? 3'(1 << g) : 3'b000;
      chk("reqReady", 32'(bus.reqReady), 32'(expReady));
      if (!r) begin
         mPtr = 0; mLast = 0; mCount = 0; mWr = '0; mWd = '0; mEn = 1'b0;
      end else begin
         mEn = 1'b0;
         if (g >= 0) begin
            mWr   = regs[g*5 +: 5];
            mWd   = data[g*32 +: 32];
            mEn   = (mWr != 5'd0);
            mLast = g;
            mPtr  = (g + 1) % 3;
         end
         if (!h && $countones(v) >= 2 && mCount < 65535) mCount++;
      end
      e.wr  = mWr;
      e.wd  = mWd;
      e.en  = mEn;
      e.lg  = 2'(mLast);
      e.cnt = 16'(mCount);
      sbq.push_back(e);
   endtask

   initial begin
      logic [14:0] allRegs;
      logic [95:0] allData;
      reset           = 1'b0;
      bus.hold        = 1'b0;
      bus.reqValid    = '0;
      bus.reqRegister = '0;
      bus.reqData     = '0;

      // Reset then idle for 10 cycles.
      cycle(3'b000, '0, '0, 1'b0, 1'b0);
      cycle(3'b000, '0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) cycle(3'b000, '0, '0, 1'b0, 1'b1);

      // Single source: requester 1 writes reg 5.
      cycle(3'b010, regsOf(5'd9, 5'd5, 5'd7), dataOf(32'h1111_1111, 32'hDEAD_BEEF, 32'h2222_2222), 1'b0, 1'b1);
      cycle(3'b000, '0, '0, 1'b0, 1'b1);

      // Fairness from reset: all valid for 6 cycles.
      cycle(3'b000, '0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         allRegs = regsOf(5'(3*i + 1), 5'(3*i + 2), 5'(3*i + 3));
         allData = dataOf($urandom, $urandom, $urandom);
         cycle(3'b111, allRegs, allData, 1'b0, 1'b1);
      end
      cycle(3'b000, '0, '0, 1'b0, 1'b1);
      chk("fairCount", 32'(bus.contentionCount), 32'd6);

      // Register 0 drop from requester 2, then contended grant goes to 0.
      cycle(3'b100, regsOf(5'd3, 5'd4, 5'd0), dataOf(32'h0, 32'h0, 32'h0000_1234), 1'b0, 1'b1);
      cycle(3'b111, regsOf(5'd10, 5'd11, 5'd12), dataOf(32'hA0A0_A0A0, 32'hB1B1_B1B1, 32'hC2C2_C2C2), 1'b0, 1'b1);
      cycle(3'b000, '0, '0, 1'b0, 1'b1);

      // Hold with all valid: no grant, no count.
      cycle(3'b111, regsOf(5'd1, 5'd2, 5'd3), dataOf(32'h5, 32'h6, 32'h7), 1'b1, 1'b1);
      cycle(3'b111, regsOf(5'd1, 5'd2, 5'd3), dataOf(32'h5, 32'h6, 32'h7), 1'b1, 1'b1);

      // Mid-stream reset right after a transfer; pointer returns to 0.
      cycle(3'b110, regsOf(5'd1, 5'd20, 5'd21), dataOf(32'h0, 32'hFACE_0001, 32'hFACE_0002), 1'b0, 1'b1);
      cycle(3'b111, regsOf(5'd1, 5'd2, 5'd3), dataOf(32'h5, 32'h6, 32'h7), 1'b0, 1'b0);
      cycle(3'b111, regsOf(5'd13, 5'd14, 5'd15), dataOf(32'h8, 32'h9, 32'hA), 1'b0, 1'b1);
      cycle(3'b000, '0, '0, 1'b0, 1'b1);

      // Saturation: more than 65535 contended cycles.
      for (int i = 0; i < 65540; i++) begin
         cycle(3'b011, regsOf(5'd16, 5'd17, 5'd18), dataOf(32'(i), 32'(~i), 32'h0), 1'b0, 1'b1);
      end
      cycle(3'b111, regsOf(5'd16, 5'd17, 5'd18), dataOf(32'h1, 32'h2, 32'h3), 1'b0, 1'b1);
      cycle(3'b000, '0, '0, 1'b0, 1'b1);
      @(negedge clk);
      drain();
      chk("saturated", 32'(bus.contentionCount), 32'h0000_FFFF);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the register file's single write port (writeRegister/writeData/enableWrite) among NUM_REQ writeback sources, e.g. ALU, load unit and multi-cycle mult/div.
- Arbitration: round-robin, with a valid/ready handshake per requester.
- Output: one registered write-port stage that drives the register file directly.
- Monitoring: a saturating contention counter for performance checks.

Parameters:
NUM_REQ, 3, number of writeback requesters (>=2)
REG_SIZE, 32, data width of one register
FILE_SIZE, 32, number of registers; index width RW = $clog2(FILE_SIZE)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset (reset==0 at a rising edge resets all state)
reqValid  input  NUM_REQ  bit i: requester i has a pending write
reqReady  output  NUM_REQ  bit i: requester i granted this cycle (combinational)
reqRegister  input  NUM_REQ*RW  flattened; slice i = [i*RW +: RW] is the destination register index
reqData  input  NUM_REQ*REG_SIZE  flattened; slice i = [i*REG_SIZE +: REG_SIZE] is the write data
hold  input  1  pipeline stall; when 1, no grant is issued
writeRegister  output  RW  to register file writeRegister (registered)
writeData  output  REG_SIZE  to register file writeData (registered)
enableWrite  output  1  to register file enableWrite (registered)
lastGrant  output  $clog2(NUM_REQ)  index of the most recently accepted requester (registered)
contentionCount  output  16  saturating count of contended cycles (registered)

Behaviour:
- Handshake:
  - Transfer of requester i occurs in cycle N iff reqValid[i] && reqReady[i].
  - reqReady is zero or one-hot and never depends on reqData or reqRegister.
  - When hold==1 or reset==0, reqReady = 0.
- Round-robin:
  - Internal pointer ptr in 0..NUM_REQ-1.
  - Grant goes to the first i with reqValid[i]=1, searching ptr, ptr+1, ..., wrapping modulo NUM_REQ.
  - After a transfer from i: ptr <= (i+1) mod NUM_REQ and lastGrant <= i.
  - With no transfer, ptr and lastGrant are unchanged.
- Latency:
  - A transfer in cycle N presents writeRegister/writeData in cycle N+1, so the register file captures the value at the end of cycle N+1.
  - enableWrite = 1 in cycle N+1 iff a transfer occurred in N and reqRegister != 0.
- No transfer in cycle N (including because of hold): enableWrite = 0 in N+1; writeRegister and writeData hold their previous values.
- Register 0 destination:
  - Handshake completes normally (ready asserted, ptr advances).
  - writeRegister = 0 and writeData is loaded, but enableWrite = 0, so the write is silently dropped.
- Throughput: one write per cycle sustained; no internal queueing and no backpressure from the register file.
- Requester rules:
  - A requester may drop reqValid before being granted; the arbiter keeps no memory of un-granted requests.
  - A requester should keep data stable while valid.
- contentionCount:
  - Increments by 1 in every cycle with hold==0 and popcount(reqValid) >= 2.
  - Saturates at 16'hFFFF and never wraps.
- Reset (reset==0 at an edge, including mid-stream):
  - ptr = 0, lastGrant = 0, enableWrite = 0, writeRegister = 0, writeData = 0, contentionCount = 0.
  - reqReady = 0 during the reset cycle.
  - A write accepted in the cycle before reset is lost: enableWrite is 0 in the cycle after the reset edge.
- Simultaneous hold and valid: hold wins; no grant, no counter increment, ptr unchanged.
- Invariant: at most one enableWrite pulse per transfer; never an enableWrite without a preceding transfer.

Test Plan:
- Reset then idle: all outputs 0; reqReady=0; enableWrite stays 0 for 10 cycles.
- Single source: requester 1 valid, reg 5, data 0xDEADBEEF at cycle N.
  - Cycle N: reqReady=3'b010.
  - Cycle N+1: writeRegister=5, writeData=0xDEADBEEF, enableWrite=1, lastGrant=1.
- Fairness: all 3 requesters continuously valid for 6 cycles from reset.
  - Grants are 0,1,2,0,1,2 with one enableWrite per cycle.
  - contentionCount=6.
- Register 0 drop: requester 2 writes reg 0, data 0x1234.
  - reqReady[2]=1 and writeRegister=0 next cycle, with enableWrite=0.
  - ptr advances, so the next contended grant goes to requester 0.
- Hold and mid-stream reset:
  - hold=1 with all valid: reqReady=0, enableWrite=0 next cycle, count unchanged.
  - reset=0 one cycle after a transfer: enableWrite=0 after the reset edge, count=0, ptr=0.
- Saturation: force 65,540 contended cycles; contentionCount=0xFFFF and holds.
